// File: rtl/vga_frame_ram_pkg.sv
// Shared types and helpers for the dual-port VGA frame RAM.
// Parity helpers are used only when VGA_FRAME_RAM_PARITY_EN is defined.
package vga_frame_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  localparam int PAR_MAX_W = 256;

  function automatic int LANE_W(input int dw, input int lanes);
    return dw / lanes;
  endfunction

  // Even parity: stored bit makes the lane plus parity have an even count of ones.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vga_frame_ram_port_pipe.sv
// Per-port read output stage: bypass merge plus 1 or 2 register stages.
// Carries a parity error flag when VGA_FRAME_RAM_PARITY_EN is defined.
module vga_frame_ram_port_pipe
  import vga_frame_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd,
  input  logic [DATA_WIDTH-1:0] i_raw,
  input  logic [LANES-1:0]      i_bmask,
  input  logic [DATA_WIDTH-1:0] i_bdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid
`ifdef VGA_FRAME_RAM_PARITY_EN
  ,
  input  logic [LANES-1:0]      i_mis,
  output logic                  o_perr
`endif
);

  localparam int LW = LANE_W(DATA_WIDTH, LANES);

  logic [DATA_WIDTH-1:0] w_merge;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  r_v1;

  always_comb begin
    w_merge = i_raw;
    for (int l = 0; l < LANES; l++) begin
      if (i_bmask[l]) begin
        w_merge[l*LW +: LW] = i_bdata[l*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= i_rd;
      if (i_rd) begin
        r_d1 <= w_merge;
      end
    end
  end

`ifdef VGA_FRAME_RAM_PARITY_EN
  // Bypassed lanes carry fresh write data, so they never flag an error.
  logic w_perr;
  logic r_p1;

  assign w_perr = |(i_mis & ~i_bmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1 <= 1'b0;
    end else begin
      r_p1 <= i_rd & w_perr;
    end
  end
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_d2;
      logic                  r_v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_d2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= r_d1;
          end
        end
      end

      assign o_rdata  = r_d2;
      assign o_rvalid = r_v2;

`ifdef VGA_FRAME_RAM_PARITY_EN
      logic r_p2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_p2 <= 1'b0;
        end else begin
          r_p2 <= r_p1;
        end
      end
      assign o_perr = r_p2;
`endif
    end else begin : g_lat1
      assign o_rdata  = r_d1;
      assign o_rvalid = r_v1;
`ifdef VGA_FRAME_RAM_PARITY_EN
      assign o_perr = r_p1;
`endif
    end
  endgenerate

endmodule

// File: rtl/vga_frame_ram.sv
// True dual-port frame RAM with lane enables, bypass and a clear sweep.
// Define VGA_FRAME_RAM_PARITY_EN to store per-lane parity and add a_perr/b_perr.
module vga_frame_ram
  import vga_frame_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int LANES        = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [LANES-1:0]      a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [LANES-1:0]      b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  busy,
  output logic                  clear_done
`ifdef VGA_FRAME_RAM_PARITY_EN
  ,
  output logic                  a_perr,
  output logic                  b_perr
`endif
);

  localparam int LW    = LANE_W(DATA_WIDTH, LANES);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef VGA_FRAME_RAM_PARITY_EN
  localparam int SW    = DATA_WIDTH + LANES;
`else
  localparam int SW    = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [SW-1:0]         r_mem [DEPTH];
  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_sw_addr;
  logic [DATA_WIDTH-1:0] r_clr_val;
  logic                  w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sw_addr <= '0;
      r_clr_val <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && clear_req) begin
        r_sw_addr <= '0;
        r_clr_val <= clear_value;
      end else if (w_busy) begin
        r_sw_addr <= r_sw_addr + ADDR_ONE;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (clear_req) w_next = CLEAR;
      CLEAR:   if (r_sw_addr == '1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_busy     = (r_state == CLEAR);
  assign busy       = w_busy;
  assign clear_done = (r_state == DONE);
  assign a_ready    = !w_busy;
  assign b_ready    = !w_busy;

  // The sweep borrows port A's write path while user ports are held off.
  logic                  w_a_wr;
  logic                  w_b_wr;
  logic                  w_a_rd;
  logic                  w_b_rd;
  logic [ADDR_WIDTH-1:0] w_a_waddr;
  logic [DATA_WIDTH-1:0] w_a_wdat;
  logic [LANES-1:0]      w_a_wbe;

  assign w_a_wr    = (a_en && a_ready && a_we) || w_busy;
  assign w_b_wr    = b_en && b_ready && b_we;
  assign w_a_rd    = a_en && a_ready && !a_we;
  assign w_b_rd    = b_en && b_ready && !b_we;
  assign w_a_waddr = w_busy ? r_sw_addr : a_addr;
  assign w_a_wdat  = w_busy ? r_clr_val : a_wdata;
  assign w_a_wbe   = w_busy ? {LANES{1'b1}} : a_be;

  logic [SW-1:0] w_a_word;
  logic [SW-1:0] w_b_word;

  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    w_a_word[DATA_WIDTH-1:0] = w_a_wdat;
    w_b_word[DATA_WIDTH-1:0] = b_wdata;
`ifdef VGA_FRAME_RAM_PARITY_EN
    for (int l = 0; l < LANES; l++) begin
      w_a_word[DATA_WIDTH+l] = parity(PAR_MAX_W'(w_a_wdat[l*LW +: LW]));
      w_b_word[DATA_WIDTH+l] = parity(PAR_MAX_W'(b_wdata[l*LW +: LW]));
    end
`endif
  end

  // B is applied first so A wins every lane it enables on a collision.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_b_wr && b_be[l]) begin
        r_mem[b_addr][l*LW +: LW] <= w_b_word[l*LW +: LW];
`ifdef VGA_FRAME_RAM_PARITY_EN
        r_mem[b_addr][DATA_WIDTH+l] <= w_b_word[DATA_WIDTH+l];
`endif
      end
      if (w_a_wr && w_a_wbe[l]) begin
        r_mem[w_a_waddr][l*LW +: LW] <= w_a_word[l*LW +: LW];
`ifdef VGA_FRAME_RAM_PARITY_EN
        r_mem[w_a_waddr][DATA_WIDTH+l] <= w_a_word[DATA_WIDTH+l];
`endif
      end
    end
  end

  logic [SW-1:0]    w_a_q;
  logic [SW-1:0]    w_b_q;
  logic [LANES-1:0] w_a_bmask;
  logic [LANES-1:0] w_b_bmask;

  assign w_a_q     = r_mem[a_addr];
  assign w_b_q     = r_mem[b_addr];
  assign w_a_bmask = (w_b_wr && b_addr == a_addr) ? b_be : '0;
  assign w_b_bmask = (w_a_wr && w_a_waddr == b_addr) ? w_a_wbe : '0;

`ifdef VGA_FRAME_RAM_PARITY_EN
  logic [LANES-1:0] w_a_mis;
  logic [LANES-1:0] w_b_mis;

  always_comb begin
    w_a_mis = '0;
    w_b_mis = '0;
    for (int l = 0; l < LANES; l++) begin
      w_a_mis[l] = w_a_q[DATA_WIDTH+l] ^
                   parity(PAR_MAX_W'(w_a_q[l*LW +: LW]));
      w_b_mis[l] = w_b_q[DATA_WIDTH+l] ^
                   parity(PAR_MAX_W'(w_b_q[l*LW +: LW]));
    end
  end
`endif

  vga_frame_ram_port_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LANES        (LANES),
    .READ_LATENCY (READ_LATENCY)
  ) u_a_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_rd     (w_a_rd),
    .i_raw    (w_a_q[DATA_WIDTH-1:0]),
    .i_bmask  (w_a_bmask),
    .i_bdata  (b_wdata),
    .o_rdata  (a_rdata),
    .o_rvalid (a_rvalid)
`ifdef VGA_FRAME_RAM_PARITY_EN
    ,
    .i_mis    (w_a_mis),
    .o_perr   (a_perr)
`endif
  );

  vga_frame_ram_port_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LANES        (LANES),
    .READ_LATENCY (READ_LATENCY)
  ) u_b_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_rd     (w_b_rd),
    .i_raw    (w_b_q[DATA_WIDTH-1:0]),
    .i_bmask  (w_b_bmask),
    .i_bdata  (w_a_wdat),
    .o_rdata  (b_rdata),
    .o_rvalid (b_rvalid)
`ifdef VGA_FRAME_RAM_PARITY_EN
    ,
    .i_mis    (w_b_mis),
    .o_perr   (b_perr)
`endif
  );

endmodule
